mc_control: RTL

- Multi-cycle control FSM for the RV32I core. It sequences the shared memory port, the instruction register, PC update, the ALU operand muxes and register-file writeback.
- Uses the opcode of the held instruction (Instr), the same field the immediate extender decodes. Adds a memory-ready handshake with timeout, a sticky fault state and a retired-instruction counter.

---
 rtl/mc_control.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for the RV32I core.
//
// Sequences the shared memory port, instruction register load, PC update,
// ALU operand muxes and register-file writeback. The next step is chosen from
// the opcode of the held instruction. The block also provides a memory-ready
// handshake timeout, a sticky fault state and a retired-instruction counter.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   Instr           held instruction; only the opcode field is decoded
//   BrTaken         branch comparator result, used in EXEC
//   MemReady        acknowledge for the current memory request
//   MemReq/MemWe    memory request / write enable
//   AdrSrc          memory address select (0 = PC, 1 = ALU result)
//   IRWrite         instruction register load
//   PCWrite/PCSrc   PC update enable / next-PC select
//   ALUSrcA/ALUSrcB ALU operand selects
//   RegWrite        register-file write enable
//   ResultSrc       writeback data select
//   Fault           sticky fault flag; FaultCause 1 = illegal op, 2 = timeout
//   State           current state encoding (debug)
//   Retired         retired-instruction count, wraps modulo 2^CNT_W
module mc_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Instr,
    input  logic             BrTaken,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemWe,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic             Fault,
    output logic [1:0]       FaultCause,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] Retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [7:0]       TLIM    = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, nxt;
    logic [7:0]       tcnt;
    logic [1:0]       cause, cause_nxt;
    logic [CNT_W-1:0] retired;
    logic             retire;
    logic             timeout;

    // Only the opcode field steers the sequencer; the rest belongs to the datapath.
    logic [6:0] op;
    logic       unused_instr;
    assign op           = Instr[6:0];
    assign unused_instr = ^Instr[31:7];

    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic legal, srca, srcb;

    assign is_r     = (op == OP_R);
    assign is_i     = (op == OP_I);
    assign is_ld    = (op == OP_LOAD);
    assign is_st    = (op == OP_STORE);
    assign is_br    = (op == OP_BR);
    assign is_jal   = (op == OP_JAL);
    assign is_jalr  = (op == OP_JALR);
    assign is_lui   = (op == OP_LUI);
    assign is_auipc = (op == OP_AUIPC);
    assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;

    // Operand selection is fixed by opcode and kept stable from EXEC through
    // MEM/WB so the ALU result feeding the address or jump target stays valid.
    assign srca = is_auipc;
    assign srcb = is_i | is_ld | is_st | is_jalr | is_auipc;

    // The limit cycle only faults if the acknowledge is still missing.
    assign timeout = (tcnt == TLIM) && !MemReady;

    always_comb begin
        nxt        = state;
        cause_nxt  = cause;
        retire     = 1'b0;
        MemReq     = 1'b0;
        MemWe      = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 2'd0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'd0;
        Fault      = 1'b0;
        FaultCause = cause;
        State      = state;
        Retired    = retired;

        case (state)
            S_FETCH: begin
                MemReq = 1'b1;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    nxt     = S_DECODE;
                end else if (timeout) begin
                    nxt       = S_FAULT;
                    cause_nxt = 2'd2;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    nxt = S_EXEC;
                end else begin
                    nxt       = S_FAULT;
                    cause_nxt = 2'd1;
                end
            end
            S_EXEC: begin
                ALUSrcA = srca;
                ALUSrcB = srcb;
                if (is_ld || is_st) begin
                    nxt = S_MEM;
                end else if (is_br) begin
                    PCWrite = 1'b1;
                    PCSrc   = BrTaken ? 2'd1 : 2'd0;
                    retire  = 1'b1;
                    nxt     = S_FETCH;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                MemReq  = 1'b1;
                AdrSrc  = 1'b1;
                MemWe   = is_st;
                ALUSrcA = srca;
                ALUSrcB = srcb;
                if (MemReady) begin
                    if (is_st) begin
                        PCWrite = 1'b1;
                        retire  = 1'b1;
                        nxt     = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (timeout) begin
                    nxt       = S_FAULT;
                    cause_nxt = 2'd2;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                ALUSrcA  = srca;
                ALUSrcB  = srcb;
                retire   = 1'b1;
                nxt      = S_FETCH;
                if (is_ld)                 ResultSrc = 2'd1;
                else if (is_jal || is_jalr) ResultSrc = 2'd2;
                else if (is_lui)           ResultSrc = 2'd3;
                if (is_jal)       PCSrc = 2'd1;
                else if (is_jalr) PCSrc = 2'd2;
            end
            S_FAULT: begin
                Fault = 1'b1;
            end
            default: begin
                nxt = S_FETCH;
            end
        endcase

        // Reset silences every output, including a request in flight.
        if (rst) begin
            MemReq     = 1'b0;
            MemWe      = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            PCSrc      = 2'd0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = 2'd0;
            Fault      = 1'b0;
            FaultCause = 2'd0;
            State      = 3'd0;
            Retired    = '0;
            retire     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            cause   <= 2'd0;
            retired <= '0;
            tcnt    <= 8'd0;
        end else begin
            state <= nxt;
            cause <= cause_nxt;
            if (retire) retired <= retired + CNT_ONE;
            // Any state change restarts the wait count, so FETCH and MEM
            // always begin counting from zero.
            if (nxt != state)
                tcnt <= 8'd0;
            else if (MemReq && !MemReady)
                tcnt <= tcnt + 8'd1;
        end
    end

endmodule
